// File: rtl/ysyx_22041207_pipe_stage.sv
// Pipeline stage register: valid/ready payload slot with flush-to-bubble,
// an optional two-entry skid buffer and a saturating stall-cycle counter.
module ysyx_22041207_pipe_stage #(
  parameter int                DATA_W   = 96,
  parameter bit                SKID     = 1'b1,
  parameter logic [DATA_W-1:0] NOP_DATA = DATA_W'({64'h0, 32'h00000013}),
  parameter int                CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              m_valid_q, m_valid_d;
  logic [DATA_W-1:0] m_data_q,  m_data_d;
  logic              s_valid_q, s_valid_d;
  logic [DATA_W-1:0] s_data_q,  s_data_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic              acc, pop;

  // With SKID=0 the ready path is combinational through out_ready.
  assign in_ready  = SKID ? !s_valid_q : (!m_valid_q | out_ready);
  assign acc       = in_valid & in_ready;
  assign pop       = m_valid_q & out_ready;
  assign out_valid = m_valid_q;
  assign out_data  = m_valid_q ? m_data_q : NOP_DATA;
  assign occupancy = {1'b0, m_valid_q} + {1'b0, s_valid_q};
  assign stall_cnt = stall_cnt_q;

  always_comb begin
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    s_valid_d = s_valid_q;
    s_data_d  = s_data_q;
    if (flush) begin
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end else if (SKID) begin
      if (!m_valid_q || pop) begin
        // Skid entry is older than anything arriving now, so it goes first.
        if (s_valid_q) begin
          m_valid_d = 1'b1;
          m_data_d  = s_data_q;
          s_valid_d = 1'b0;
        end else if (acc) begin
          m_valid_d = 1'b1;
          m_data_d  = in_data;
        end else begin
          m_valid_d = 1'b0;
        end
      end else if (acc) begin
        s_valid_d = 1'b1;
        s_data_d  = in_data;
      end
    end else begin
      s_valid_d = 1'b0;
      if (acc) begin
        m_valid_d = 1'b1;
        m_data_d  = in_data;
      end else if (pop) begin
        m_valid_d = 1'b0;
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (m_valid_q && !out_ready && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid_q   <= 1'b0;
      m_data_q    <= NOP_DATA;
      s_valid_q   <= 1'b0;
      s_data_q    <= NOP_DATA;
      stall_cnt_q <= '0;
    end else begin
      m_valid_q   <= m_valid_d;
      m_data_q    <= m_data_d;
      s_valid_q   <= s_valid_d;
      s_data_q    <= s_data_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_ysyx_22041207_pipe_stage.sv
// Scoreboard bench for the pipe stage: one SKID=1 and one SKID=0 instance,
// each with its own queue of expected held entries and stall-cycle model.
module tb_ysyx_22041207_pipe_stage;

  localparam logic [95:0] NOP = {64'h0, 32'h00000013};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        s1_flush = 1'b0, s1_in_valid = 1'b0, s1_out_ready = 1'b1;
  logic [95:0] s1_in_data = '0;
  logic        s1_in_ready, s1_out_valid;
  logic [95:0] s1_out_data;
  logic [1:0]  s1_occupancy;
  logic [31:0] s1_stall_cnt;

  logic        s0_flush = 1'b0, s0_in_valid = 1'b0, s0_out_ready = 1'b1;
  logic [95:0] s0_in_data = '0;
  logic        s0_in_ready, s0_out_valid;
  logic [95:0] s0_out_data;
  logic [1:0]  s0_occupancy;
  logic [31:0] s0_stall_cnt;

  ysyx_22041207_pipe_stage #(.DATA_W(96), .SKID(1'b1), .NOP_DATA(NOP), .CNT_W(32)) u_dut_skid (
    .clk(clk), .rst(rst), .flush(s1_flush),
    .in_valid(s1_in_valid), .in_ready(s1_in_ready), .in_data(s1_in_data),
    .out_valid(s1_out_valid), .out_ready(s1_out_ready), .out_data(s1_out_data),
    .occupancy(s1_occupancy), .stall_cnt(s1_stall_cnt)
  );

  ysyx_22041207_pipe_stage #(.DATA_W(96), .SKID(1'b0), .NOP_DATA(NOP), .CNT_W(32)) u_dut_noskid (
    .clk(clk), .rst(rst), .flush(s0_flush),
    .in_valid(s0_in_valid), .in_ready(s0_in_ready), .in_data(s0_in_data),
    .out_valid(s0_out_valid), .out_ready(s0_out_ready), .out_data(s0_out_data),
    .occupancy(s0_occupancy), .stall_cnt(s0_stall_cnt)
  );

  int checks = 0;
  int failures = 0;
  logic [95:0] q1[$];
  logic [95:0] q0[$];
  logic [31:0] sc1 = '0;
  logic [31:0] sc0 = '0;
  bit last_acc1, last_acc0;

  task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", tag, act, exp);
    end
  endtask

  function automatic logic [95:0] pl(input int k);
    return {64'h80000000 + 64'(4 * k), 32'(k)};
  endfunction

  // Called at posedge+1: samples at the falling edge, updates models, advances one edge.
  task automatic cycle();
    bit rdy1, rdy0, pop1, pop0;
    #4;
    check_eq("s1_valid", 128'(s1_out_valid), 128'(q1.size() != 0));
    if (q1.size() != 0) check_eq("s1_data", 128'(s1_out_data), 128'(q1[0]));
    else                check_eq("s1_nop", 128'(s1_out_data), 128'(NOP));
    check_eq("s1_occ", 128'(s1_occupancy), 128'(q1.size()));
    rdy1 = (q1.size() < 2);
    check_eq("s1_in_ready", 128'(s1_in_ready), 128'(rdy1));
    check_eq("s1_stall", 128'(s1_stall_cnt), 128'(sc1));
    pop1 = (q1.size() != 0) && s1_out_ready;
    last_acc1 = s1_in_valid && rdy1;
    if ((q1.size() != 0) && !s1_out_ready && (sc1 != '1)) sc1++;
    if (pop1) $display("s1 pop data=%h", q1.pop_front());
    if (s1_flush) q1.delete();
    else if (last_acc1) q1.push_back(s1_in_data);

    check_eq("s0_valid", 128'(s0_out_valid), 128'(q0.size() != 0));
    if (q0.size() != 0) check_eq("s0_data", 128'(s0_out_data), 128'(q0[0]));
    else                check_eq("s0_nop", 128'(s0_out_data), 128'(NOP));
    check_eq("s0_occ", 128'(s0_occupancy), 128'(q0.size()));
    rdy0 = (q0.size() == 0) || s0_out_ready;
    check_eq("s0_in_ready", 128'(s0_in_ready), 128'(rdy0));
    check_eq("s0_stall", 128'(s0_stall_cnt), 128'(sc0));
    pop0 = (q0.size() != 0) && s0_out_ready;
    last_acc0 = s0_in_valid && rdy0;
    if ((q0.size() != 0) && !s0_out_ready && (sc0 != '1)) sc0++;
    if (pop0) $display("s0 pop data=%h", q0.pop_front());
    if (s0_flush) q0.delete();
    else if (last_acc0) q0.push_back(s0_in_data);

    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check_eq({pfx, "_s1_valid"}, 128'(s1_out_valid), 128'(0));
    check_eq({pfx, "_s1_data"},  128'(s1_out_data),  128'(NOP));
    check_eq({pfx, "_s1_ready"}, 128'(s1_in_ready),  128'(1));
    check_eq({pfx, "_s1_occ"},   128'(s1_occupancy), 128'(0));
    check_eq({pfx, "_s1_stall"}, 128'(s1_stall_cnt), 128'(0));
    check_eq({pfx, "_s0_valid"}, 128'(s0_out_valid), 128'(0));
    check_eq({pfx, "_s0_data"},  128'(s0_out_data),  128'(NOP));
    check_eq({pfx, "_s0_ready"}, 128'(s0_in_ready),  128'(1));
  endtask

  initial begin
    int idx;
    #2;
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) cycle();

    // Streaming through the skid stage at full rate
    for (int k = 0; k < 8; k++) begin
      s1_in_valid = 1'b1;
      s1_in_data  = pl(k);
      s1_out_ready = 1'b1;
      cycle();
    end
    s1_in_valid = 1'b0;
    repeat (2) cycle();

    // Backpressure: head stalls for three cycles while input keeps offering
    idx = 0;
    for (int c = 0; c < 12; c++) begin
      s1_out_ready = !(c >= 1 && c <= 3);
      s1_in_valid  = (idx < 4);
      s1_in_data   = pl(100 + idx);
      cycle();
      if (last_acc1) idx++;
      if (c == 3) begin
        check_eq("bp_stall3", 128'(s1_stall_cnt), 128'(3));
        check_eq("bp_occ2", 128'(s1_occupancy), 128'(2));
        check_eq("bp_ready0", 128'(s1_in_ready), 128'(0));
      end
    end
    check_eq("bp_all_accepted", 128'(idx), 128'(4));
    s1_in_valid = 1'b0;
    s1_out_ready = 1'b1;
    repeat (2) cycle();

    // Flush with main and skid both full and input offering
    s1_out_ready = 1'b0;
    s1_in_valid  = 1'b1;
    s1_in_data   = pl(200);
    cycle();
    s1_in_data   = pl(201);
    cycle();
    s1_in_data   = pl(202);
    s1_flush     = 1'b1;
    cycle();
    s1_flush     = 1'b0;
    s1_in_valid  = 1'b0;
    check_eq("flush_valid", 128'(s1_out_valid), 128'(0));
    check_eq("flush_occ", 128'(s1_occupancy), 128'(0));
    check_eq("flush_data", 128'(s1_out_data), 128'(NOP));
    cycle();
    // Flush coinciding with a pop and an accept: pop completes, accept is dropped
    s1_out_ready = 1'b1;
    s1_in_valid  = 1'b1;
    s1_in_data   = pl(203);
    cycle();
    s1_in_data   = pl(204);
    s1_flush     = 1'b1;
    cycle();
    s1_flush     = 1'b0;
    s1_in_valid  = 1'b0;
    repeat (3) cycle();

    // SKID=0: ready follows out_ready combinationally while main is full
    s0_out_ready = 1'b0;
    s0_in_valid  = 1'b1;
    s0_in_data   = pl(400);
    cycle();
    idx = 1;
    for (int c = 0; c < 3; c++) begin
      s0_out_ready = (c != 1);
      s0_in_data   = pl(400 + idx);
      cycle();
      if (last_acc0) idx++;
    end
    check_eq("s0_toggle_accepts", 128'(idx), 128'(3));
    s0_in_valid  = 1'b0;
    s0_out_ready = 1'b1;
    repeat (3) cycle();

    // Random traffic on both stages
    for (int c = 0; c < 150; c++) begin
      s1_in_valid  = 1'($urandom_range(0, 1));
      s1_out_ready = 1'($urandom_range(0, 1));
      s1_flush     = ($urandom_range(0, 15) == 0);
      s1_in_data   = {$urandom, $urandom, $urandom};
      s0_in_valid  = 1'($urandom_range(0, 1));
      s0_out_ready = 1'($urandom_range(0, 1));
      s0_flush     = ($urandom_range(0, 15) == 0);
      s0_in_data   = {$urandom, $urandom, $urandom};
      cycle();
    end
    s1_flush = 1'b0; s1_in_valid = 1'b0; s1_out_ready = 1'b1;
    s0_flush = 1'b0; s0_in_valid = 1'b0; s0_out_ready = 1'b1;
    repeat (3) cycle();

    // Async reset mid-stall with two entries held and stall_cnt at 5
    rst = 1'b1;
    #1;
    rst = 1'b0;
    q1.delete(); q0.delete();
    sc1 = '0; sc0 = '0;
    @(posedge clk);
    #1;
    s1_out_ready = 1'b0;
    s1_in_valid  = 1'b1;
    s1_in_data   = pl(300);
    cycle();
    s1_in_data   = pl(301);
    cycle();
    s1_in_valid  = 1'b0;
    repeat (4) cycle();
    check_eq("pre_rst_occ", 128'(s1_occupancy), 128'(2));
    check_eq("pre_rst_stall", 128'(s1_stall_cnt), 128'(5));
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    q1.delete(); q0.delete();
    sc1 = '0; sc0 = '0;
    #2;
    rst = 1'b0;
    s1_out_ready = 1'b1;
    @(posedge clk);
    #1;
    repeat (2) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
